berexp_cmp_stream: RTL and testbench
====================================

# berexp_cmp_stream

Parametrised, fully handshaked Bernoulli-exp decision back-end for the Falcon sampler. It takes a fixed-point approximate exponential and a shift amount, forms z = (2·exp − 1) >> s, and compares z MSB-first against random bytes drawn from an RNG stream. It emits w = (random < z). It sits between the ApproxExp stage and the sampler's rejection logic, replacing the fixed 8-byte, no-backpressure compare stage with a stream-driven one.

## Interface
- Z_W, 64, width of exp/z in bits; must be a multiple of BYTE_W
- BYTE_W, 8, random byte width
- CONST_TIME, 0, 0 = stop at first unequal byte; 1 = always consume NB = Z_W/BYTE_W bytes
- S_W, 8, width of s_i
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- din_val_i  in  1  exp_i/s_i valid
- din_rdy_o  out  1  block accepts a new operand
- exp_i  in  Z_W  ApproxExp result, unsigned fixed point
- s_i  in  S_W  shift amount, unsigned; saturated internally to Z_W−1
- rnd_val_i  in  1  random byte valid
- rnd_rdy_o  out  1  block consumes a random byte
- rnd_i  in  BYTE_W  random byte
- dout_val_o  out  1  result valid
- dout_rdy_i  in  1  downstream accepts result
- w_o  out  1  Bernoulli decision
- nbytes_o  out  $clog2(NB+1)  random bytes consumed for this result

## Operation
- Handshakes: a transfer occurs on a rising edge where val and rdy are both 1. Once dout_val_o is high, w_o and nbytes_o stay stable until the transfer.
- s_sat = min(s_i, Z_W−1), latched on input accept.
- z arithmetic: compute {exp, 1'b0} − 1 at Z_W+1 bits, modulo 2^(Z_W+1), shift right by s_sat, keep the low Z_W bits. exp = 0 wraps to all ones.
- Byte k (k = 0 … NB−1) is z[Z_W−1−k·BYTE_W −: BYTE_W]. Byte 0 is the MSB byte.
- FSM IDLE: din_rdy_o = 1. On accept, latch exp and s_sat and go to LOAD.
- FSM LOAD: register z, clear idx, clear decided, go to CMP.
- FSM CMP: rnd_rdy_o = 1. On each rnd transfer, compare rnd_i with byte idx.
  - If the bytes differ and decided = 0, set w = (rnd_i < byte) and decided = 1.
  - If CONST_TIME = 0 and the bytes differ, go to DONE.
  - Otherwise, if idx = NB−1, go to DONE (if still undecided, w = 0).
  - Otherwise idx++.
- FSM DONE: dout_val_o = 1. On output transfer, go to IDLE.
- Same-cycle event in DONE: din_rdy_o = dout_rdy_i, so output and input may transfer together. In that case the next state is LOAD, with no bubble.
- rnd_rdy_o = 0 outside CMP. Random bytes are never consumed in IDLE, LOAD or DONE.
- nbytes_o = number of rnd transfers in the current CMP visit, from 1 to NB.
- In CONST_TIME = 1, bytes after the decision are consumed and ignored. The first difference wins.

## Timing
- Reset (rst = 0) forces state IDLE and w_o = 0, nbytes_o = 0, dout_val_o = 0, rnd_rdy_o = 0, din_rdy_o = 0.
- din_rdy_o rises in the first cycle after rst deassertion, from a registered reset-release flag.
- Reset mid-operation aborts the current operand. Consumed bytes are discarded and no result is produced.
- Latency: input accept at edge 0, LOAD in cycle 1, first byte compared at edge 2.
- With rnd_val_i held high, dout_val_o is high in cycle k+2, where k = nbytes.
- CONST_TIME = 1 gives a fixed NB+2 cycles.
- rnd_val_i low stalls CMP with no state change. dout_rdy_i low holds DONE indefinitely.
- Throughput: one result per k+2 cycles when dout_rdy_i = 1.

## Structure
- Package berexp_pkg holds:
  - state typedef berexp_cmp_state_t {IDLE, LOAD, CMP, DONE};
  - shared constants POW_2_63, INV_LN_2, LN_2;
  - function nbytes(Z_W, BYTE_W).
- Sub-module berexp_zshift: purely combinational. Takes exp and s_sat, returns z, implementing saturation and the Z_W+1-bit wrap rule. It is reused by later sampler variants.

## Test plan
- Lazy mode, exp_i = 64'h4000_0000_0000_0000, s_i = 0, so z = 64'h7FFF_FFFF_FFFF_FFFF.
  - rnd 8'h7E gives w = 1, nbytes = 1, dout_val_o at cycle 3.
  - rnd 8'h80 gives w = 0, nbytes = 1.
- CONST_TIME = 1, same operand, rnd 8'h7E followed by 7 random bytes: w = 1, nbytes = 8, dout_val_o at cycle 10.
- exp_i = 64'h8000_0000_0000_0000, s_i = 200 (saturates to 63), so z = 1.
  - rnd 00×8 gives w = 1, nbytes = 8.
  - rnd 00×7 then 01 gives w = 0.
- All 8 rnd bytes equal to the z bytes: w = 0, nbytes = 8.
- Backpressure:
  - rnd_val_i toggling 1010 stretches CMP to match.
  - dout_rdy_i low for 5 cycles holds w_o and nbytes_o with din_rdy_o = 0.
  - Then dout_rdy_i and din_val_i high in the same cycle: both transfer and LOAD is next.
- rst pulled low after 3 of 8 bytes (CONST_TIME = 1):
  - all outputs go 0 asynchronously;
  - din_rdy_o returns one cycle after release;
  - the next operand produces the correct w and nbytes.

Source files
------------

// File: rtl/berexp_cmp_stream_pkg.sv
// -----------------------------------------------------------------------------
// berexp_pkg
// Shared definitions for the Bernoulli-exp decision back-end of the Falcon
// sampler.
//   berexp_cmp_state_t : compare-stream FSM states
//   POW_2_63           : 2^63 as a 64-bit unsigned constant
//   INV_LN_2           : 1/ln(2) in unsigned Q1.63 (rounded)
//   LN_2               : ln(2) in unsigned Q0.64 (rounded)
//   nbytes()           : number of random bytes needed to cover a z word
// -----------------------------------------------------------------------------
package berexp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } berexp_cmp_state_t;

    localparam logic [63:0] POW_2_63 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] INV_LN_2 = 64'hB8AA_3B29_5C17_F0BC;
    localparam logic [63:0] LN_2     = 64'hB172_17F7_D1CF_79AC;

    // z is compared one random byte at a time, MSB byte first.
    function automatic int nbytes(input int z_w, input int byte_w);
        return z_w / byte_w;
    endfunction

endpackage

// File: rtl/berexp_cmp_stream_zshift.sv
// -----------------------------------------------------------------------------
// berexp_zshift
// Purely combinational z former: z = ((2*exp - 1) mod 2^(Z_W+1)) >> min(s, Z_W-1),
// truncated to Z_W bits. exp = 0 wraps to an all-ones z before the shift.
// Ports:
//   exp_i : Z_W-bit unsigned fixed-point ApproxExp result
//   s_i   : S_W-bit unsigned shift amount (saturated here to Z_W-1)
//   z_o   : Z_W-bit comparison threshold
// -----------------------------------------------------------------------------
module berexp_zshift #(
    parameter int Z_W = 64,
    parameter int S_W = 8
) (
    input  logic [Z_W-1:0] exp_i,
    input  logic [S_W-1:0] s_i,
    output logic [Z_W-1:0] z_o
);

    localparam int SH_W = (Z_W > 1) ? $clog2(Z_W) : 1;
    localparam int CW   = (S_W > 32) ? S_W : 32;

    logic [CW-1:0]   s_ext;
    logic [SH_W-1:0] s_sat;
    logic [Z_W:0]    twice_m1;

    // Widen before comparing so any S_W works against the Z_W-1 limit.
    assign s_ext = CW'(s_i);
    assign s_sat = (s_ext >= CW'(Z_W - 1)) ? SH_W'(Z_W - 1) : SH_W'(s_ext);

    // One extra bit keeps the doubled value exact; the subtraction wraps
    // modulo 2^(Z_W+1), which is what makes exp = 0 produce all ones.
    assign twice_m1 = {exp_i, 1'b0} - {{Z_W{1'b0}}, 1'b1};
    assign z_o      = Z_W'(twice_m1 >> s_sat);

endmodule

// File: rtl/berexp_cmp_stream.sv
// -----------------------------------------------------------------------------
// berexp_cmp_stream
// Stream-driven Bernoulli-exp decision: w = (random < z), where z is formed
// from an ApproxExp result and a shift, and the random number arrives MSB
// byte first on a handshaked byte stream.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-low reset
//   din_val_i / din_rdy_o : operand handshake carrying exp_i and s_i
//   exp_i       : Z_W-bit ApproxExp result
//   s_i         : S_W-bit shift amount
//   rnd_val_i / rnd_rdy_o : random byte handshake carrying rnd_i
//   rnd_i       : BYTE_W-bit random byte
//   dout_val_o / dout_rdy_i : result handshake carrying w_o and nbytes_o
//   w_o         : Bernoulli decision
//   nbytes_o    : random bytes consumed for this result (1..NB)
//   state_o     : current FSM state (debug visibility)
//
// Handshake rule for all three channels: a transfer happens on a rising clk
// edge where valid and ready are both 1; a producer holding valid keeps its
// payload stable until that edge.
// -----------------------------------------------------------------------------
module berexp_cmp_stream
    import berexp_pkg::*;
#(
    parameter int Z_W        = 64,
    parameter int BYTE_W     = 8,
    parameter int CONST_TIME = 0,
    parameter int S_W        = 8,
    localparam int NB        = nbytes(Z_W, BYTE_W),
    localparam int NBW       = $clog2(NB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_val_i,
    output logic              din_rdy_o,
    input  logic [Z_W-1:0]    exp_i,
    input  logic [S_W-1:0]    s_i,
    input  logic              rnd_val_i,
    output logic              rnd_rdy_o,
    input  logic [BYTE_W-1:0] rnd_i,
    output logic              dout_val_o,
    input  logic              dout_rdy_i,
    output logic              w_o,
    output logic [NBW-1:0]    nbytes_o,
    output logic [1:0]        state_o
);

    localparam int SH_W = (Z_W > 1) ? $clog2(Z_W) : 1;
    localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW   = (S_W > 32) ? S_W : 32;

    berexp_cmp_state_t state;
    logic              rel_q;      // set on the first clock after reset release
    logic [Z_W-1:0]    exp_q;
    logic [SH_W-1:0]   s_q;
    logic [Z_W-1:0]    z_q;
    logic [Z_W-1:0]    z_next;
    logic [IW-1:0]     idx;
    logic              decided;
    logic              w_q;
    logic [NBW-1:0]    cnt;

    logic [CW-1:0]     s_ext;
    logic [SH_W-1:0]   s_sat;
    logic [BYTE_W-1:0] z_bytes [NB];
    logic [BYTE_W-1:0] cur_byte;
    logic              differ;
    logic              rnd_lt;
    logic              in_fire;

    // Shift saturation applied at accept so only SH_W bits are stored.
    assign s_ext = CW'(s_i);
    assign s_sat = (s_ext >= CW'(Z_W - 1)) ? SH_W'(Z_W - 1) : SH_W'(s_ext);

    berexp_zshift #(
        .Z_W (Z_W),
        .S_W (SH_W)
    ) u_zshift (
        .exp_i (exp_q),
        .s_i   (s_q),
        .z_o   (z_next)
    );

    // Byte 0 is the most significant byte of z.
    for (genvar k = 0; k < NB; k++) begin : g_bytes
        assign z_bytes[k] = z_q[Z_W-1-k*BYTE_W -: BYTE_W];
    end

    assign cur_byte = z_bytes[idx];
    assign differ   = (rnd_i != cur_byte);
    assign rnd_lt   = (rnd_i < cur_byte);

    // In DONE the input side opens only when the result leaves in the same
    // cycle, so a new operand can follow without a bubble.
    always_comb begin
        din_rdy_o = 1'b0;
        if (rel_q) begin
            if (state == IDLE)
                din_rdy_o = 1'b1;
            else if (state == DONE)
                din_rdy_o = dout_rdy_i;
        end
    end

    assign in_fire    = din_val_i & din_rdy_o;
    assign rnd_rdy_o  = (state == CMP);
    assign dout_val_o = (state == DONE);
    assign w_o        = w_q;
    assign nbytes_o   = cnt;
    assign state_o    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rel_q   <= 1'b0;
            exp_q   <= '0;
            s_q     <= '0;
            z_q     <= '0;
            idx     <= '0;
            decided <= 1'b0;
            w_q     <= 1'b0;
            cnt     <= '0;
        end else begin
            rel_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        exp_q <= exp_i;
                        s_q   <= s_sat;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    z_q     <= z_next;
                    idx     <= '0;
                    decided <= 1'b0;
                    w_q     <= 1'b0;
                    cnt     <= '0;
                    state   <= CMP;
                end
                CMP: begin
                    if (rnd_val_i) begin
                        cnt <= cnt + NBW'(1);
                        // First differing byte decides; later ones are ignored.
                        if (differ && !decided) begin
                            w_q     <= rnd_lt;
                            decided <= 1'b1;
                        end
                        if (differ && (CONST_TIME == 0))
                            state <= DONE;
                        else if (idx == IW'(NB - 1))
                            state <= DONE;  // undecided here means equal: w stays 0
                        else
                            idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (dout_rdy_i) begin
                        if (in_fire) begin
                            exp_q <= exp_i;
                            s_q   <= s_sat;
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_berexp_cmp_stream.sv
module tb_berexp_cmp_stream;
    import berexp_pkg::*;

    localparam int NB = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        din_val  = 1'b0;
    logic [63:0] exp_v    = '0;
    logic [7:0]  s_v      = '0;
    logic        rnd_val  = 1'b0;
    logic [7:0]  rnd      = '0;
    logic        dout_rdy = 1'b1;

    // lazy instance (CONST_TIME = 0) and constant-time instance (CONST_TIME = 1)
    logic       l_din_rdy, l_rnd_rdy, l_dout_val, l_w;
    logic [3:0] l_nb;
    logic [1:0] l_state;
    logic       c_din_rdy, c_rnd_rdy, c_dout_val, c_w;
    logic [3:0] c_nb;
    logic [1:0] c_state;

    berexp_cmp_stream #(.Z_W(64), .BYTE_W(8), .CONST_TIME(0), .S_W(8)) u_lazy (
        .clk(clk), .rst(rst),
        .din_val_i(din_val), .din_rdy_o(l_din_rdy), .exp_i(exp_v), .s_i(s_v),
        .rnd_val_i(rnd_val), .rnd_rdy_o(l_rnd_rdy), .rnd_i(rnd),
        .dout_val_o(l_dout_val), .dout_rdy_i(dout_rdy), .w_o(l_w), .nbytes_o(l_nb),
        .state_o(l_state)
    );

    berexp_cmp_stream #(.Z_W(64), .BYTE_W(8), .CONST_TIME(1), .S_W(8)) u_ct (
        .clk(clk), .rst(rst),
        .din_val_i(din_val), .din_rdy_o(c_din_rdy), .exp_i(exp_v), .s_i(s_v),
        .rnd_val_i(rnd_val), .rnd_rdy_o(c_rnd_rdy), .rnd_i(rnd),
        .dout_val_o(c_dout_val), .dout_rdy_i(dout_rdy), .w_o(c_w), .nbytes_o(c_nb),
        .state_o(c_state)
    );

    // selected instance view
    bit         mode = 1'b0;
    logic       din_rdy, rnd_rdy, dout_val, w;
    logic [3:0] nb;
    logic [1:0] state;
    assign din_rdy  = mode ? c_din_rdy  : l_din_rdy;
    assign rnd_rdy  = mode ? c_rnd_rdy  : l_rnd_rdy;
    assign dout_val = mode ? c_dout_val : l_dout_val;
    assign w        = mode ? c_w        : l_w;
    assign nb       = mode ? c_nb       : l_nb;
    assign state    = mode ? c_state    : l_state;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_z(input logic [63:0] e, input logic [7:0] s);
        logic [64:0] two_e_m1;
        int sh;
        two_e_m1 = 65'(e) * 65'd2 - 65'd1;
        sh = (int'(s) > 63) ? 63 : int'(s);
        return 64'(two_e_m1 >> sh);
    endfunction

    // bytes consumed: all of them in constant time, else up to the first difference
    function automatic int model_nb(input logic [63:0] z, input logic [63:0] r, input bit ct);
        if (ct) return NB;
        for (int k = 0; k < NB; k++)
            if (z[63-8*k -: 8] != r[63-8*k -: 8]) return k + 1;
        return NB;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        din_val = 1'b0; rnd_val = 1'b0; dout_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_operand(input logic [63:0] e, input logic [7:0] s);
        int n = 0;
        while (din_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_wait: din_rdy_o=%b, required 1 within 50 cycles", din_rdy);
        end
        din_val = 1'b1; exp_v = e; s_v = s;
        @(posedge clk);
        #1 din_val = 1'b0;
    endtask

    // Starts right after the accept edge; returns at the negedge where the
    // result is first visible, leaving dout_rdy untouched.
    task automatic collect(input logic [63:0] r, input bit stall,
                           output logic w_obs, output int nb_obs, output int lat, output int consumed);
        int  cyc  = 0;
        bit  seen = 1'b0;
        consumed = 0; w_obs = 1'b0; nb_obs = 0; lat = -1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dout_val === 1'b1) begin
                seen = 1'b1; lat = cyc; w_obs = w; nb_obs = int'(nb);
                rnd_val = 1'b0;
            end else begin
                rnd_val = stall ? (cyc % 2 == 0) : 1'b1;
                rnd = (consumed < NB) ? r[63-8*consumed -: 8] : 8'($urandom);
                if (rnd_val && rnd_rdy === 1'b1) consumed++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL result_wait: dout_val_o=%b, required 1 within 100 cycles", dout_val);
        end
    endtask

    task automatic do_op(input logic [63:0] e, input logic [7:0] s, input logic [63:0] r, input bit stall,
                         output logic w_obs, output int nb_obs, output int lat, output int consumed);
        send_operand(e, s);
        collect(r, stall, w_obs, nb_obs, lat, consumed);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({l_din_rdy, l_rnd_rdy, l_dout_val, l_w, l_nb, c_din_rdy, c_rnd_rdy, c_dout_val, c_w, c_nb} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: lazy=%b%b%b%b/%h ct=%b%b%b%b/%h, required all 0",
                     l_din_rdy, l_rnd_rdy, l_dout_val, l_w, l_nb, c_din_rdy, c_rnd_rdy, c_dout_val, c_w, c_nb);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({l_din_rdy, c_din_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_early: din_rdy_o=%b%b, required 00 before first edge", l_din_rdy, c_din_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if ({l_din_rdy, c_din_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_rdy: din_rdy_o=%b%b, required 11 after first edge", l_din_rdy, c_din_rdy);
        end
        @(negedge clk);
    endtask

    task automatic test_lazy_basic();
        logic wo; int n, lat, cons;
        mode = 1'b0;
        apply_reset();
        do_op(64'h4000_0000_0000_0000, 8'd0, {8'h7E, 56'($urandom) << 24 | 56'($urandom)}, 1'b0, wo, n, lat, cons);
        checks++;
        if (wo !== 1'b1 || n != 1 || lat != 3 || cons != 1) begin
            errors++;
            $display("FAIL lazy_7e: w=%b nbytes=%0d lat=%0d used=%0d, required w=1 nbytes=1 lat=3 used=1", wo, n, lat, cons);
        end
        do_op(64'h4000_0000_0000_0000, 8'd0, {8'h80, 56'($urandom)}, 1'b0, wo, n, lat, cons);
        checks++;
        if (wo !== 1'b0 || n != 1 || lat != 3) begin
            errors++;
            $display("FAIL lazy_80: w=%b nbytes=%0d lat=%0d, required w=0 nbytes=1 lat=3", wo, n, lat);
        end
    endtask

    task automatic test_const_time();
        logic wo; int n, lat, cons;
        mode = 1'b1;
        apply_reset();
        do_op(64'h4000_0000_0000_0000, 8'd0, {8'h7E, 56'($urandom) << 24 | 56'($urandom)}, 1'b0, wo, n, lat, cons);
        checks++;
        if (wo !== 1'b1 || n != 8 || lat != 10 || cons != 8) begin
            errors++;
            $display("FAIL ct_7e: w=%b nbytes=%0d lat=%0d used=%0d, required w=1 nbytes=8 lat=10 used=8", wo, n, lat, cons);
        end
    endtask

    task automatic test_saturate();
        logic wo; int n, lat, cons;
        for (int m = 0; m < 2; m++) begin
            mode = bit'(m);
            apply_reset();
            do_op(64'h8000_0000_0000_0000, 8'd200, 64'h0, 1'b0, wo, n, lat, cons);
            checks++;
            if (wo !== 1'b1 || n != 8 || lat != 10) begin
                errors++;
                $display("FAIL sat_zero mode=%0d: w=%b nbytes=%0d lat=%0d, required w=1 nbytes=8 lat=10", m, wo, n, lat);
            end
            do_op(64'h8000_0000_0000_0000, 8'd200, 64'h1, 1'b0, wo, n, lat, cons);
            checks++;
            if (wo !== 1'b0 || n != 8 || lat != 10) begin
                errors++;
                $display("FAIL sat_one mode=%0d: w=%b nbytes=%0d lat=%0d, required w=0 nbytes=8 lat=10", m, wo, n, lat);
            end
        end
    endtask

    task automatic test_equal();
        logic wo; int n, lat, cons;
        for (int m = 0; m < 2; m++) begin
            mode = bit'(m);
            apply_reset();
            do_op(64'h4000_0000_0000_0000, 8'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, wo, n, lat, cons);
            checks++;
            if (wo !== 1'b0 || n != 8 || lat != 10) begin
                errors++;
                $display("FAIL equal mode=%0d: w=%b nbytes=%0d lat=%0d, required w=0 nbytes=8 lat=10", m, wo, n, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic wo; int n, lat, cons;
        mode = 1'b0;
        apply_reset();
        // rnd_val_i toggling: bytes land only on even cycles
        do_op(64'h4000_0000_0000_0000, 8'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, wo, n, lat, cons);
        checks++;
        if (wo !== 1'b0 || n != 8 || lat != 17 || cons != 8) begin
            errors++;
            $display("FAIL rnd_stall: w=%b nbytes=%0d lat=%0d used=%0d, required w=0 nbytes=8 lat=17 used=8", wo, n, lat, cons);
        end
        // hold the result for 5 cycles while a new operand waits
        send_operand(64'h4000_0000_0000_0000, 8'd0);
        collect({8'h7E, 56'h0}, 1'b0, wo, n, lat, cons);
        dout_rdy = 1'b0;
        din_val = 1'b1; exp_v = {$urandom, $urandom}; s_v = 8'($urandom);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checks++;
            if (dout_val !== 1'b1 || w !== 1'b1 || nb !== 4'd1 || din_rdy !== 1'b0) begin
                errors++;
                $display("FAIL dout_hold[%0d]: val=%b w=%b nbytes=%0d din_rdy=%b, required 1 1 1 0", h, dout_val, w, nb, din_rdy);
            end
        end
        // release output and present the next operand in the same cycle
        exp_v = 64'h8000_0000_0000_0000; s_v = 8'd200; dout_rdy = 1'b1;
        #1;
        checks++;
        if (din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdy: din_rdy_o=%b, required 1", din_rdy);
        end
        @(posedge clk); #1;
        din_val = 1'b0;
        checks++;
        if (state !== 2'(LOAD) || dout_val !== 1'b0 || rnd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: state=%0d dout_val=%b rnd_rdy=%b, required LOAD 0 0", state, dout_val, rnd_rdy);
        end
        collect(64'h0, 1'b0, wo, n, lat, cons);
        checks++;
        if (wo !== 1'b1 || n != 8 || lat != 10) begin
            errors++;
            $display("FAIL b2b_result: w=%b nbytes=%0d lat=%0d, required w=1 nbytes=8 lat=10", wo, n, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic wo; int n, lat, cons;
        logic [7:0] seq [3];
        seq[0] = 8'h7E; seq[1] = 8'h11; seq[2] = 8'h22;
        mode = 1'b1;
        apply_reset();
        send_operand(64'h4000_0000_0000_0000, 8'd0);
        cons = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            rnd_val = 1'b1;
            rnd = seq[(cons < 3) ? cons : 2];
            if (rnd_rdy === 1'b1) cons++;
        end
        @(negedge clk);
        rnd_val = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({w, nb, dout_val, rnd_rdy, din_rdy} !== 8'h0 || cons != 3) begin
            errors++;
            $display("FAIL mid_reset: w=%b nbytes=%0d val=%b rnd_rdy=%b din_rdy=%b used=%0d, required all 0, used=3",
                     w, nb, dout_val, rnd_rdy, din_rdy, cons);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (din_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_early: din_rdy_o=%b, required 0", din_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (din_rdy !== 1'b1 || dout_val !== 1'b0) begin
            errors++;
            $display("FAIL mid_release_rdy: din_rdy_o=%b dout_val=%b, required 1 0", din_rdy, dout_val);
        end
        @(negedge clk);
        do_op(64'h4000_0000_0000_0000, 8'd0, {8'h80, 56'($urandom)}, 1'b0, wo, n, lat, cons);
        checks++;
        if (wo !== 1'b0 || n != 8 || lat != 10) begin
            errors++;
            $display("FAIL mid_next_op: w=%b nbytes=%0d lat=%0d, required w=0 nbytes=8 lat=10", wo, n, lat);
        end
    endtask

    task automatic test_random();
        logic wo; int n, lat, cons;
        logic [63:0] e, z, r, mask;
        logic [7:0]  s;
        logic        w_e;
        int          nb_e, lat_e, j;
        bit          stall;
        for (int m = 0; m < 2; m++) begin
            mode = bit'(m);
            apply_reset();
            for (int t = 0; t < 30; t++) begin
                e = {$urandom, $urandom};
                if ($urandom_range(0, 5) == 0) e = 64'h0;
                s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
                z = model_z(e, s);
                case ($urandom_range(0, 3))
                    0: r = {$urandom, $urandom};
                    1: r = z;
                    2: begin
                        j = $urandom_range(1, 7);
                        mask = ~64'h0 << (64 - 8 * j);
                        r = (z & mask) | ({$urandom, $urandom} & ~mask);
                    end
                    default: r = ($urandom_range(0, 1) == 1) ? z + 64'd1 : z - 64'd1;
                endcase
                stall = bit'($urandom_range(0, 1));
                w_e   = (r < z);
                nb_e  = model_nb(z, r, bit'(m));
                lat_e = stall ? 2 * nb_e + 1 : nb_e + 2;
                do_op(e, s, r, stall, wo, n, lat, cons);
                checks++;
                if (wo !== w_e || n != nb_e) begin
                    errors++;
                    $display("FAIL rand_result mode=%0d t=%0d: w=%b nbytes=%0d, required w=%b nbytes=%0d (exp=%h s=%0d r=%h)",
                             m, t, wo, n, w_e, nb_e, e, s, r);
                end
                checks++;
                if (lat != lat_e || cons != nb_e) begin
                    errors++;
                    $display("FAIL rand_timing mode=%0d t=%0d: lat=%0d used=%0d, required lat=%0d used=%0d",
                             m, t, lat, cons, lat_e, nb_e);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lazy_basic();
        test_const_time();
        test_saturate();
        test_equal();
        test_backpressure();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
